sig4hz_stopwatch: RTL and testbench

//  Downstream consumer of the 4 Hz divider output. Edge-detects the 4 Hz square

---
 rtl/sig4hz_stopwatch.sv | 183 ++++++++++++++++++
 tb/tb_sig4hz_stopwatch.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sig4hz_stopwatch.sv
// rtl/sig4hz_stopwatch.sv - BCD mm:ss stopwatch clocked by rising edges of a 4 Hz signal
//
// Purpose:
//   Detects rising edges of the 4 Hz divider output and prescales them to
//   1 s. It runs a BCD mm:ss stopwatch with IDLE/RUN/PAUSE control.
//
// Optional feature macro: SW_LAP_EN
//   This macro adds the iLAP input and the lap-hold display latch.
//
// Ports:
//   iCLK         in   1  system clock; iSIG_4Hz is synchronous to it
//   iRST_N       in   1  asynchronous reset, active low
//   iSIG_4Hz     in   1  4 Hz square wave
//   iSTART_STOP  in   1  one-cycle pulse: toggle run
//   iCLEAR       in   1  one-cycle pulse: stop and zero (wins over start/stop)
//   iLAP         in   1  (SW_LAP_EN only) one-cycle pulse: toggle lap hold in RUN
//   oSEC_ONES    out  4  BCD seconds units
//   oSEC_TENS    out  4  BCD seconds tens
//   oMIN_ONES    out  4  BCD minutes units
//   oMIN_TENS    out  4  BCD minutes tens
//   oRUNNING     out  1  high while in RUN
//   oWRAP        out  1  one-cycle pulse on 59:59 -> 00:00
module sig4hz_stopwatch #(
  parameter int TICKS_PER_SEC = 4,
  parameter int PRE_W         = 2
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSIG_4Hz,
  input  logic       iSTART_STOP,
  input  logic       iCLEAR,
`ifdef SW_LAP_EN
  input  logic       iLAP,
`endif
  output logic [3:0] oSEC_ONES,
  output logic [3:0] oSEC_TENS,
  output logic [3:0] oMIN_ONES,
  output logic [3:0] oMIN_TENS,
  output logic       oRUNNING,
  output logic       oWRAP
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } stateT;

  stateT            state, stateNext;
  logic             sigQ;
  logic             tick;
  logic [PRE_W-1:0] pre, preNext;
  logic [3:0]       secOnes, secTens, minOnes, minTens;
  logic [3:0]       secOnesNext, secTensNext, minOnesNext, minTensNext;
  logic             wrapNext;

  // The edge register resets high, so a signal that is already high at reset
  // release is not counted as a rising edge.
  assign tick = iSIG_4Hz & ~sigQ;

  always_comb begin
    stateNext = state;
    if (iCLEAR) begin
      stateNext = IDLE;
    end else if (iSTART_STOP) begin
      case (state)
        IDLE:    stateNext = RUN;
        RUN:     stateNext = PAUSE;
        PAUSE:   stateNext = RUN;
        default: stateNext = IDLE;
      endcase
    end
  end

  // The tick is judged against the current state. A start/stop pulse in the
  // same cycle only affects the following cycles.
  always_comb begin
    preNext     = pre;
    secOnesNext = secOnes;
    secTensNext = secTens;
    minOnesNext = minOnes;
    minTensNext = minTens;
    wrapNext    = 1'b0;
    if (iCLEAR || state == IDLE) begin
      preNext     = '0;
      secOnesNext = 4'd0;
      secTensNext = 4'd0;
      minOnesNext = 4'd0;
      minTensNext = 4'd0;
    end else if (state == RUN && tick) begin
      if (pre != PRE_LAST) begin
        preNext = pre + 1'b1;
      end else begin
        preNext = '0;
        if (secOnes != 4'd9) begin
          secOnesNext = secOnes + 4'd1;
        end else begin
          secOnesNext = 4'd0;
          if (secTens != 4'd5) begin
            secTensNext = secTens + 4'd1;
          end else begin
            secTensNext = 4'd0;
            if (minOnes != 4'd9) begin
              minOnesNext = minOnes + 4'd1;
            end else begin
              minOnesNext = 4'd0;
              if (minTens != 4'd5) begin
                minTensNext = minTens + 4'd1;
              end else begin
                minTensNext = 4'd0;
                wrapNext    = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= IDLE;
      sigQ     <= 1'b1;
      pre      <= '0;
      secOnes  <= 4'd0;
      secTens  <= 4'd0;
      minOnes  <= 4'd0;
      minTens  <= 4'd0;
      oRUNNING <= 1'b0;
      oWRAP    <= 1'b0;
    end else begin
      state    <= stateNext;
      sigQ     <= iSIG_4Hz;
      pre      <= preNext;
      secOnes  <= secOnesNext;
      secTens  <= secTensNext;
      minOnes  <= minOnesNext;
      minTens  <= minTensNext;
      oRUNNING <= (stateNext == RUN);
      oWRAP    <= wrapNext;
    end
  end

`ifdef SW_LAP_EN
  logic       lapHold;
  logic [3:0] lapSecOnes, lapSecTens, lapMinOnes, lapMinTens;

  // The lap latch captures the time shown before this cycle's increment.
  // Counting continues underneath the held display.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      lapHold    <= 1'b0;
      lapSecOnes <= 4'd0;
      lapSecTens <= 4'd0;
      lapMinOnes <= 4'd0;
      lapMinTens <= 4'd0;
    end else if (iCLEAR) begin
      lapHold <= 1'b0;
    end else if (iLAP && state == RUN) begin
      lapHold <= ~lapHold;
      if (!lapHold) begin
        lapSecOnes <= secOnes;
        lapSecTens <= secTens;
        lapMinOnes <= minOnes;
        lapMinTens <= minTens;
      end
    end
  end

  assign oSEC_ONES = lapHold ? lapSecOnes : secOnes;
  assign oSEC_TENS = lapHold ? lapSecTens : secTens;
  assign oMIN_ONES = lapHold ? lapMinOnes : minOnes;
  assign oMIN_TENS = lapHold ? lapMinTens : minTens;
`else
  assign oSEC_ONES = secOnes;
  assign oSEC_TENS = secTens;
  assign oMIN_ONES = minOnes;
  assign oMIN_TENS = minTens;
`endif

endmodule

// File: tb/tb_sig4hz_stopwatch.sv
// tb/tb_sig4hz_stopwatch.sv - self-checking bench for sig4hz_stopwatch
module tb_sig4hz_stopwatch;
  localparam int TPS = 4;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       iSIG_4Hz = 1'b1;
  logic       iSTART_STOP = 1'b0;
  logic       iCLEAR = 1'b0;
`ifdef SW_LAP_EN
  logic       iLAP = 1'b0;
`endif
  logic [3:0] oSEC_ONES, oSEC_TENS, oMIN_ONES, oMIN_TENS;
  logic       oRUNNING, oWRAP;

  sig4hz_stopwatch #(.TICKS_PER_SEC(TPS), .PRE_W(2)) dut (
    .iCLK(iCLK),
    .iRST_N(iRST_N),
    .iSIG_4Hz(iSIG_4Hz),
    .iSTART_STOP(iSTART_STOP),
    .iCLEAR(iCLEAR),
`ifdef SW_LAP_EN
    .iLAP(iLAP),
`endif
    .oSEC_ONES(oSEC_ONES),
    .oSEC_TENS(oSEC_TENS),
    .oMIN_ONES(oMIN_ONES),
    .oMIN_TENS(oMIN_TENS),
    .oRUNNING(oRUNNING),
    .oWRAP(oWRAP)
  );

  always #5 iCLK = ~iCLK;

  int checkCount = 0;
  int failCount  = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: counted ticks since the last clear, modulo one hour.
  int mTicks;
  int mState;      // 0 idle, 1 run, 2 pause
  bit mSigQ;
  bit mWrap;
  bit mHold;
  int mLapSec;
  int wrapSeen;

  function automatic int timeSec();
    return mTicks / TPS;
  endfunction

  function automatic logic [15:0] bcdOf(input int s);
    int m, ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] shown();
    return {oMIN_TENS, oMIN_ONES, oSEC_TENS, oSEC_ONES};
  endfunction

  task automatic modelReset();
    mTicks = 0; mState = 0; mSigQ = 1'b1; mWrap = 1'b0; mHold = 1'b0; mLapSec = 0;
  endtask

  task automatic step(input bit sig, input bit ss, input bit clr, input bit lap);
    bit tick;
    iSIG_4Hz = sig; iSTART_STOP = ss; iCLEAR = clr;
`ifdef SW_LAP_EN
    iLAP = lap;
`endif
    @(posedge iCLK);
    tick  = sig && !mSigQ;
    mSigQ = sig;
    if (clr) begin
      mTicks = 0; mState = 0; mWrap = 1'b0; mHold = 1'b0;
    end else begin
      mWrap = 1'b0;
`ifdef SW_LAP_EN
      if (lap && mState == 1) begin
        if (!mHold) begin mHold = 1'b1; mLapSec = timeSec(); end
        else mHold = 1'b0;
      end
`endif
      if (mState == 1 && tick) begin
        mTicks++;
        if (mTicks == TPS * 3600) begin mTicks = 0; mWrap = 1'b1; end
      end
      if (ss) mState = (mState == 1) ? 2 : 1;
    end
    #1;
    iSTART_STOP = 1'b0; iCLEAR = 1'b0;
`ifdef SW_LAP_EN
    iLAP = 1'b0;
`endif
    checkVal("digits", 32'(shown()), 32'(bcdOf(mHold ? mLapSec : timeSec())));
    checkVal("running", 32'(oRUNNING), 32'(mState == 1));
    checkVal("wrap", 32'(oWRAP), 32'(mWrap));
    if (oWRAP) wrapSeen++;
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    modelReset();
    wrapSeen = 0;
    // Reset with the signal high.
    repeat (3) @(posedge iCLK);
    #1;
    checkVal("rst_digits", 32'(shown()), 32'h0);
    checkVal("rst_running", 32'(oRUNNING), 32'h0);
    checkVal("rst_wrap", 32'(oWRAP), 32'h0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    edges(8);
    checkVal("t1_no_count", 32'(shown()), 32'h0);

    // Start and count whole seconds.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    edges(4);
    checkVal("t2_1s", 32'(shown()), 32'h0001);
    edges(36);
    checkVal("t2_10s", 32'(shown()), 32'h0010);

    // The prescaler holds its value across a pause.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    edges(2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    edges(5);
    checkVal("t3_paused", 32'(shown()), 32'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    edges(2);
    checkVal("t3_resume", 32'(shown()), 32'h0001);

    // Clear and start/stop arrive with the fourth tick; clear wins.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    edges(3);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checkVal("t5_digits", 32'(shown()), 32'h0000);
    checkVal("t5_running", 32'(oRUNNING), 32'h0);

`ifdef SW_LAP_EN
    step(1'b0, 1'b1, 1'b0, 1'b0);
    edges(20);
    checkVal("t6_at5", 32'(shown()), 32'h0005);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    edges(8);
    checkVal("t6_held", 32'(shown()), 32'h0005);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("t6_live", 32'(shown()), 32'h0007);
    step(1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Randomized control and signal activity.
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 11) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset in the middle of a count.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    edges(9);
    iSIG_4Hz = 1'b1;
    #2;
    iRST_N = 1'b0;
    #1;
    checkVal("midrst_digits", 32'(shown()), 32'h0);
    checkVal("midrst_running", 32'(oRUNNING), 32'h0);
    modelReset();
    @(negedge iCLK);
    iRST_N = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Run to 59:58, then cross the wrap.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    edges((59 * 60 + 58) * TPS);
    checkVal("t4_5958", 32'(shown()), 32'h5958);
    wrapSeen = 0;
    edges(8);
    checkVal("t4_wrapped", 32'(shown()), 32'h0000);
    checkVal("t4_wrap_pulses", 32'(wrapSeen), 32'd1);
    checkVal("t4_running", 32'(oRUNNING), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
